// File: rtl/md_unit.sv
// md_unit: multiply/divide unit holding the architectural HI/LO registers.
//
// Ports
//   clk    in   1  single clock, all state changes on the rising edge
//   reset  in   1  synchronous active-high reset
//   A      in  32  rs operand (GRF RD1 path)
//   B      in  32  rt operand (GRF RD2 path)
//   MDOp   in   3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 madd
//   Start  in   1  qualifies MDOp for one cycle; ignored while Busy=1
//   HI     out 32  architectural HI register
//   LO     out 32  architectural LO register
//   Busy   out  1  high while a multi-cycle operation is in flight
//
// Configuration
//   MD_UNIT_MADD_EN  when defined, MDOp=7 performs madd:
//                    {HI,LO} <= {HI,LO} + signed(A*B), with a 5-cycle busy window.
//                    When undefined, MDOp=7 is ignored like MDOp=0.
//
// Timing model
//   The result is computed from the operands captured on the accepting edge and
//   parked in a pending register. A down-counter times the busy window, and the
//   pending result is committed on the edge where the counter goes 1 -> 0, which
//   is the same edge Busy falls. Until then HI/LO keep their pre-command values.

module md_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [2:0]  MDOp,
    input  logic        Start,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic        Busy
);

    // Command encodings
    localparam logic [2:0] OpNone  = 3'd0;
    localparam logic [2:0] OpMult  = 3'd1;
    localparam logic [2:0] OpMultu = 3'd2;
    localparam logic [2:0] OpDiv   = 3'd3;
    localparam logic [2:0] OpDivu  = 3'd4;
    localparam logic [2:0] OpMthi  = 3'd5;
    localparam logic [2:0] OpMtlo  = 3'd6;
    localparam logic [2:0] OpMadd  = 3'd7;

    // Busy-window lengths in cycles
    localparam logic [3:0] MulCycles = 4'd5;
    localparam logic [3:0] DivCycles = 4'd10;

    // What to do with the pending value on the final edge
    localparam logic [1:0] PendNone  = 2'd0; // discard (divide by zero)
    localparam logic [1:0] PendWrite = 2'd1; // {HI,LO} <= pend
    localparam logic [1:0] PendAcc   = 2'd2; // {HI,LO} <= {HI,LO} + pend

    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic [3:0]  cnt_q;
    logic [63:0] pend_q;
    logic [1:0]  pend_kind_q;

    logic        accept;
    logic [63:0] prod_signed;
    logic [63:0] prod_unsigned;
    logic        div_signed;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] quot;
    logic [31:0] rem;
    logic        div_by_zero;

    assign Busy   = (cnt_q != 4'd0);
    assign HI     = hi_q;
    assign LO     = lo_q;
    assign accept = Start && !Busy;

    // Products are formed at 64 bits on extended operands; the low 64 bits of the
    // product of sign-extended values is exactly the two's-complement product.
    always_comb begin
        prod_signed   = {{32{A[31]}}, A} * {{32{B[31]}}, B};
        prod_unsigned = {32'd0, A} * {32'd0, B};
    end

    // Division is done on magnitudes and the signs are restored afterwards. This
    // gives truncation toward zero, a remainder with the dividend's sign, and
    // makes 0x80000000 / -1 wrap to 0x80000000 without relying on overflowing
    // signed division semantics.
    always_comb begin
        div_signed  = (MDOp == OpDiv);
        a_neg       = div_signed && A[31];
        b_neg       = div_signed && B[31];
        a_mag       = a_neg ? (~A + 32'd1) : A;
        b_mag       = b_neg ? (~B + 32'd1) : B;
        div_by_zero = (B == 32'd0);
        if (div_by_zero) begin
            q_mag = 32'd0;
            r_mag = 32'd0;
        end else begin
            q_mag = a_mag / b_mag;
            r_mag = a_mag % b_mag;
        end
        quot = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
        rem  = a_neg ? (~r_mag + 32'd1) : r_mag;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            // Clearing the counter also drops any pending commit
            hi_q        <= 32'd0;
            lo_q        <= 32'd0;
            cnt_q       <= 4'd0;
            pend_q      <= 64'd0;
            pend_kind_q <= PendNone;
        end else if (accept) begin
            case (MDOp)
                OpMult: begin
                    pend_q      <= prod_signed;
                    pend_kind_q <= PendWrite;
                    cnt_q       <= MulCycles;
                end
                OpMultu: begin
                    pend_q      <= prod_unsigned;
                    pend_kind_q <= PendWrite;
                    cnt_q       <= MulCycles;
                end
                OpDiv, OpDivu: begin
                    pend_q      <= {rem, quot};
                    pend_kind_q <= div_by_zero ? PendNone : PendWrite;
                    cnt_q       <= DivCycles;
                end
                OpMthi: begin
                    hi_q <= A;
                end
                OpMtlo: begin
                    lo_q <= A;
                end
                OpMadd: begin
`ifdef MD_UNIT_MADD_EN
                    // Accumulation happens on the final edge against the HI/LO
                    // present then; only the product is captured now.
                    pend_q      <= prod_signed;
                    pend_kind_q <= PendAcc;
                    cnt_q       <= MulCycles;
`endif
                end
                OpNone: begin
                end
                default: begin
                end
            endcase
        end else if (Busy) begin
            cnt_q <= cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
                case (pend_kind_q)
                    PendWrite: begin
                        hi_q <= pend_q[63:32];
                        lo_q <= pend_q[31:0];
                    end
                    PendAcc: begin
                        {hi_q, lo_q} <= {hi_q, lo_q} + pend_q;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed scenarios plus randomized commands
// compared against a behavioural model of HI/LO built on plain 64-bit arithmetic.

module tb_md_unit;

    logic        clk;
    logic        reset;
    logic [31:0] A;
    logic [31:0] B;
    logic [2:0]  MDOp;
    logic        Start;
    logic [31:0] HI;
    logic [31:0] LO;
    logic        Busy;

    int n_checks;
    int n_pass;

    // Reference architectural state
    logic [31:0] hi_m;
    logic [31:0] lo_m;

    md_unit dut (
        .clk   (clk),
        .reset (reset),
        .A     (A),
        .B     (B),
        .MDOp  (MDOp),
        .Start (Start),
        .HI    (HI),
        .LO    (LO),
        .Busy  (Busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Cycles Busy stays high for a command (0 = single-cycle / ignored)
    function automatic int latency(input logic [2:0] op);
        case (op)
            3'd1, 3'd2: return 5;
            3'd3, 3'd4: return 10;
`ifdef MD_UNIT_MADD_EN
            3'd7:       return 5;
`endif
            default:    return 0;
        endcase
    endfunction

    // Architectural effect of a command on (hi, lo)
    task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         inout logic [31:0] hi, inout logic [31:0] lo);
        longint sa;
        longint sb;
        longint sq;
        longint sr;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            3'd1: begin
                p = 64'(sa * sb);
                {hi, lo} = p;
            end
            3'd2: begin
                p = {32'd0, a} * {32'd0, b};
                {hi, lo} = p;
            end
            3'd3: begin
                if (b != 0) begin
                    sq = sa / sb;
                    sr = sa % sb;
                    lo = sq[31:0];
                    hi = sr[31:0];
                end
            end
            3'd4: begin
                if (b != 0) begin
                    lo = a / b;
                    hi = a % b;
                end
            end
            3'd5: hi = a;
            3'd6: lo = a;
`ifdef MD_UNIT_MADD_EN
            3'd7: begin
                p = 64'(sa * sb);
                {hi, lo} = {hi, lo} + p;
            end
`endif
            default: begin
            end
        endcase
    endtask

    // Issue one command and follow it through its busy window. With intrude set,
    // an mtlo with fresh operands is attempted at busy cycle 2 and A/B are then
    // scrambled; none of that may affect the outcome.
    task automatic run_cmd(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                           input bit intrude);
        int lat;
        logic [31:0] hi_old;
        logic [31:0] lo_old;
        lat    = latency(op);
        hi_old = hi_m;
        lo_old = lo_m;
        model(op, a, b, hi_m, lo_m);
        A     = a;
        B     = b;
        MDOp  = op;
        Start = 1'b1;
        @(posedge clk);
        #1;
        Start = 1'b0;
        MDOp  = 3'd0;
        if (lat == 0) begin
            check("nobusy", {63'd0, Busy}, 64'd0);
            check("hilo_now", {HI, LO}, {hi_m, lo_m});
        end else begin
            check("busy_rise", {63'd0, Busy}, 64'd1);
            for (int i = 1; i < lat; i++) begin
                if (intrude && i == 2) begin
                    Start = 1'b1;
                    MDOp  = 3'd6;
                    A     = $urandom;
                    B     = $urandom;
                end
                @(posedge clk);
                #1;
                Start = 1'b0;
                MDOp  = 3'd0;
                if (intrude) begin
                    A = $urandom;
                    B = $urandom;
                end
                check("busy_hold", {63'd0, Busy}, 64'd1);
                check("hilo_hold", {HI, LO}, {hi_old, lo_old});
            end
            @(posedge clk);
            #1;
            check("busy_fall", {63'd0, Busy}, 64'd0);
            check("hilo_done", {HI, LO}, {hi_m, lo_m});
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        hi_m  = 32'd0;
        lo_m  = 32'd0;
    endtask

    initial begin
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        n_checks = 0;
        n_pass   = 0;
        reset    = 1'b1;
        A        = 32'd0;
        B        = 32'd0;
        MDOp     = 3'd0;
        Start    = 1'b0;
        hi_m     = 32'd0;
        lo_m     = 32'd0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("reset_hilo", {HI, LO}, 64'd0);
        check("reset_busy", {63'd0, Busy}, 64'd0);

        // mult / multu
        run_cmd(3'd1, 32'hFFFF_FFFF, 32'd2, 1'b0);
        check("mult_spec", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFFE);
        run_cmd(3'd2, 32'hFFFF_FFFF, 32'd2, 1'b0);
        check("multu_spec", {HI, LO}, 64'h0000_0001_FFFF_FFFE);

        // signed div and the overflow corner
        run_cmd(3'd3, 32'hFFFF_FFF9, 32'd2, 1'b0);
        check("div_spec", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFFD);
        run_cmd(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        check("div_ovf", {HI, LO}, 64'h0000_0000_8000_0000);

        // divide by zero leaves HI/LO alone
        run_cmd(3'd5, 32'h11, 32'd0, 1'b0);
        run_cmd(3'd6, 32'h22, 32'd0, 1'b0);
        run_cmd(3'd4, 32'h1234, 32'd0, 1'b0);
        check("divz_spec", {HI, LO}, 64'h0000_0011_0000_0022);

        // ignored command codes
        run_cmd(3'd0, 32'hDEAD, 32'hBEEF, 1'b0);

        // busy window ignores Start and operand changes
        do_reset();
        run_cmd(3'd1, 32'd3, 32'd4, 1'b1);
        check("busywin_spec", {HI, LO}, 64'd12);

        // reset at busy cycle 6 aborts the divide
        run_cmd(3'd5, 32'h55, 32'd0, 1'b0);
        A     = 32'd100;
        B     = 32'd7;
        MDOp  = 3'd3;
        Start = 1'b1;
        @(posedge clk);
        #1;
        Start = 1'b0;
        MDOp  = 3'd0;
        for (int i = 1; i < 6; i++) begin
            @(posedge clk);
            #1;
        end
        check("abort_pre_busy", {63'd0, Busy}, 64'd1);
        do_reset();
        check("abort_busy", {63'd0, Busy}, 64'd0);
        check("abort_hilo", {HI, LO}, 64'd0);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check("abort_stay", {31'd0, Busy, HI, LO}, 64'd0);
        end

        // reset wins over Start on the same edge
        A     = 32'h77;
        MDOp  = 3'd5;
        Start = 1'b1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        Start = 1'b0;
        reset = 1'b0;
        MDOp  = 3'd0;
        check("reset_prio", {31'd0, Busy, HI, LO}, 64'd0);

        // mthi followed by a back-to-back mult
        run_cmd(3'd5, 32'hABCD, 32'd0, 1'b0);
        check("mthi_spec", {32'd0, HI}, 64'hABCD);
        run_cmd(3'd1, 32'd6, 32'hFFFF_FFFD, 1'b0);

        // madd (or ignored MDOp=7 when compiled out)
        run_cmd(3'd6, 32'hFFFF_FFFF, 32'd0, 1'b0);
        run_cmd(3'd5, 32'd0, 32'd0, 1'b0);
        run_cmd(3'd7, 32'd1, 32'd1, 1'b0);
`ifdef MD_UNIT_MADD_EN
        check("madd_spec", {HI, LO}, 64'h0000_0001_0000_0000);
`else
        check("madd_off", {HI, LO}, 64'h0000_0000_FFFF_FFFF);
`endif

        // randomized commands
        for (int n = 0; n < 150; n++) begin
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: b = 32'($urandom_range(1, 9));
                2: a = 32'h8000_0000;
                3: b = 32'hFFFF_FFFF;
                default: begin
                end
            endcase
            run_cmd(op, a, b, ($urandom_range(0, 3) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/md_unit.md
MD_UNIT -- requirements
Module: md_unit

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 The block SHALL have port A, input, 32 bits: rs operand from the GRF RD1 path.
REQ-004 The block SHALL have port B, input, 32 bits: rt operand from the GRF RD2 path.
REQ-005 The block SHALL have port MDOp, input, 3 bits, with these codes: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 madd.
REQ-006 The block SHALL have port Start, input, 1 bit: qualifies MDOp for one cycle.
REQ-007 The block SHALL have port HI, output, 32 bits: architectural HI register.
REQ-008 The block SHALL have port LO, output, 32 bits: architectural LO register.
REQ-009 The block SHALL have port Busy, output, 1 bit: high while an operation is in flight.

Function
REQ-010 The block SHALL accept a command on a rising edge only when Start=1 and Busy=0.
- While Busy=1, Start SHALL be ignored, with no effect on any state.
REQ-011 mult/multu SHALL behave as follows.
- {HI,LO} SHALL become the 64-bit signed/unsigned product of A and B.
- Busy SHALL rise on the edge that accepts the command and stay high for exactly 5 cycles.
- HI/LO SHALL update on the same edge that Busy falls.
REQ-012 div/divu SHALL behave as follows.
- LO SHALL become the quotient and HI the remainder.
- Busy SHALL stay high for exactly 10 cycles; HI/LO update as in REQ-011.
REQ-013 Signed div SHALL truncate toward zero; the remainder SHALL take the sign of the dividend.
- 0x80000000 div 0xFFFFFFFF SHALL yield LO=0x80000000, HI=0.
REQ-014 Divide by zero (B=0) SHALL still hold Busy for 10 cycles, and SHALL leave HI and LO unchanged.
REQ-015 Operands SHALL be captured on the accepting edge.
- Changes on A/B while Busy=1 SHALL NOT affect the result.
REQ-016 mthi/mtlo SHALL write A into HI/LO on the accepting edge.
- Busy SHALL stay 0 and the other register SHALL be unchanged.
REQ-017 The following SHALL cause no state change: Start=1 with MDOp=0, and MDOp=7 when madd is compiled out.
REQ-018 Until the final edge, HI/LO SHALL show their pre-command values throughout the busy window.
REQ-019 An internal down-counter SHALL time the busy window.
- Busy SHALL equal (counter != 0).
- Back-to-back commands SHALL be possible: a new Start SHALL be accepted on the first edge where Busy=0.

Reset
REQ-020 When reset=1 at a rising edge, HI, LO, the counter and Busy SHALL become 0, and any pending result SHALL be discarded.
REQ-021 Reset SHALL take priority over Start on the same edge.
REQ-022 Reset asserted mid-operation SHALL abort the operation: no late HI/LO write SHALL ever occur.

Configuration
REQ-023 The macro MD_UNIT_MADD_EN SHALL control madd support.
- Defined: MDOp=7 SHALL behave as madd, i.e. {HI,LO} <= {HI,LO} + signed(A*B) mod 2^64, with a 5-cycle busy window.
- The accumulate SHALL use the HI/LO value present at the final edge.
- Undefined: MDOp=7 SHALL be ignored per REQ-017.

Verification
REQ-024 Scenario mult.
- Stimulus: A=0xFFFFFFFF, B=2, mult.
- Required: Busy high 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE; with multu, HI=1, LO=0xFFFFFFFE.
REQ-025 Scenario div.
- Stimulus: A=-7 (0xFFFFFFF9), B=2, div.
- Required: Busy 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- Stimulus: divu with B=0 after HI=0x11, LO=0x22.
- Required: HI=0x11, LO=0x22 after 10 cycles.
REQ-026 Scenario busy window.
- Stimulus: mult 3*4 in flight; at cycle 2 apply Start with mtlo A=9, and change A/B.
- Required: both ignored; final HI=0, LO=12.
REQ-027 Scenario reset mid-operation.
- Stimulus: div started; reset pulsed at busy cycle 6.
- Required: Busy=0, HI=LO=0 the next cycle, and they stay 0 for 10 cycles.
REQ-028 Scenario back-to-back and mthi.
- Stimulus: mthi A=0xABCD, then mult accepted on the first Busy=0 edge.
- Required: HI=0xABCD the next cycle; the second product appears exactly 5 cycles after its acceptance.
REQ-029 Scenario madd, with MD_UNIT_MADD_EN defined.
- Stimulus: HI=0, LO=0xFFFFFFFF, then madd A=1, B=1.
- Required: HI=1, LO=0.
- Required with the macro undefined: no change and Busy stays 0.
